// File: rtl/mem_scan_sched.sv
// Round-robin scheduler sharing one synchronous-read memory port between NREQ
// scan requesters; each job sweeps [base, last] (with wrap) and returns min or max.
module mem_scan_sched #(
  parameter int NREQ = 2,
  parameter int AW   = 10,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_base,
  input  logic [NREQ*AW-1:0] req_last,
  input  logic [NREQ-1:0]    req_mode,
  input  logic [DW-1:0]      data,
  output logic [AW-1:0]      rd_addr,
  output logic               rd_en,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] ptr, win, pick;
  logic          any;
  logic [AW-1:0] last_q;
  logic          mode_q;
  logic [DW-1:0] acc;
  logic          vld;

  function automatic logic [DW-1:0] reduce(input logic [DW-1:0] a, input logic [DW-1:0] d,
                                           input logic mx);
    if (mx) return (d > a) ? d : a;
    else    return (d < a) ? d : a;
  endfunction

  // Walk downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        pick = IW'((int'(ptr) + i) % NREQ);
        any  = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      last_q  <= '0;
      mode_q  <= 1'b0;
      rd_addr <= '0;
      rd_en   <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      result  <= '0;
      acc     <= '0;
      vld     <= 1'b0;
    end else begin
      vld <= rd_en;
      if (vld) acc <= reduce(acc, data, mode_q);
      case (state)
        IDLE: if (any) begin
          win     <= pick;
          last_q  <= req_last[int'(pick)*AW +: AW];
          mode_q  <= req_mode[pick];
          rd_addr <= req_base[int'(pick)*AW +: AW];
          rd_en   <= 1'b1;
          gnt     <= ONE << pick;
          acc     <= req_mode[pick] ? '0 : '1;
          ptr     <= IW'((int'(pick) + 1) % NREQ);
          state   <= SCAN;
        end
        SCAN: begin
          if (rd_addr == last_q) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        // vld is high here for the last word; fold it straight into result
        DRAIN: begin
          result <= reduce(acc, data, mode_q);
          done   <= ONE << win;
          state  <= DONE;
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_sched.sv
// Directed bench for mem_scan_sched: synchronous-read memory model plus
// hand-computed expectations for each scan job.
module tb_mem_scan_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [19:0] req_base, req_last;
  logic [1:0]  req_mode;
  logic [7:0]  data = 8'h00;
  logic [9:0]  rd_addr;
  logic        rd_en;
  logic [1:0]  gnt;
  logic        busy;
  logic [1:0]  done;
  logic [7:0]  result;

  logic [7:0]  mem [1024];
  int errors = 0;
  int checks = 0;

  mem_scan_sched #(.NREQ(2), .AW(10), .DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_last(req_last),
    .req_mode(req_mode), .data(data), .rd_addr(rd_addr), .rd_en(rd_en),
    .gnt(gnt), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) data <= mem[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int i, input logic [9:0] b, input logic [9:0] l, input logic m);
    req_base[i*10 +: 10] = b;
    req_last[i*10 +: 10] = l;
    req_mode[i] = m;
  endtask

  // Starts in cycle 0 with req raised; expects done in cycle n+2.
  task automatic run_job(input string tag, input int i, input logic [9:0] b, input logic [9:0] l,
                         input logic m, input int n, input logic [7:0] r, input bit chg);
    int cyc = 0;
    int en_cnt = 0;
    int hot = 0;
    logic [9:0] first = '0;
    cfg(i, b, l, m);
    req[i] = 1'b1;
    while (done == 2'b00 && cyc < 3000) begin
      tick();
      cyc++;
      if (rd_en) begin
        if (en_cnt == 0) first = rd_addr;
        en_cnt++;
      end
      if ($countones(gnt) > 1) hot++;
      if (chg && cyc == 1) begin
        req_base[i*10 +: 10] = 10'h000;
        req_mode[i] = ~m;
        req[i] = 1'b0;
      end
    end
    chk({tag, "_done_cyc"}, cyc, n + 2);
    chk({tag, "_done_vec"}, {30'd0, done}, 32'd1 << i);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd1 << i);
    chk({tag, "_result"}, {24'd0, result}, {24'd0, r});
    chk({tag, "_rd_cnt"}, en_cnt, n);
    chk({tag, "_first_addr"}, {22'd0, first}, {22'd0, b});
    chk({tag, "_twohot"}, hot, 0);
    req[i] = 1'b0;
    tick();
    chk({tag, "_done_clr"}, {30'd0, done}, 0);
    chk({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int cyc;
    int hot;
    int seen;
    rst = 1'b1; req = '0; req_base = '0; req_last = '0; req_mode = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a + 7);
    mem[200] = 8'h03;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rd_addr", {22'd0, rd_addr}, 0);
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {30'd0, done}, 0);
    chk("rst_result", {24'd0, result}, 0);

    run_job("min_full", 0, 10'h000, 10'h3FF, 1'b0, 1024, 8'h00, 1'b0);

    mem[10'h3FE] = 8'h10; mem[10'h3FF] = 8'h90; mem[10'h000] = 8'h20; mem[10'h001] = 8'h7F;
    run_job("max_wrap", 1, 10'h3FE, 10'h001, 1'b1, 4, 8'h90, 1'b0);

    mem[10'h055] = 8'hA5;
    run_job("single", 0, 10'h055, 10'h055, 1'b0, 1, 8'hA5, 1'b0);

    // Contention: both requesters held high from reset, served 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    mem[10'h010] = 8'h05; mem[10'h011] = 8'h09; mem[10'h012] = 8'h02;
    mem[10'h020] = 8'h44; mem[10'h021] = 8'h33;
    cfg(0, 10'h010, 10'h012, 1'b1);
    cfg(1, 10'h020, 10'h021, 1'b0);
    req = 2'b11;
    hot = 0;
    for (int j = 0; j < 4; j++) begin
      cyc = 0;
      while (done == 2'b00 && cyc < 50) begin
        tick();
        cyc++;
        if ($countones(gnt) > 1) hot++;
      end
      chk("cont_done_vec", {30'd0, done}, 32'd1 << (j % 2));
      chk("cont_done_cyc", cyc, (j % 2) ? 4 : 5);
      chk("cont_result", {24'd0, result}, (j % 2) ? 32'h33 : 32'h09);
      tick();
      chk("cont_done_pulse", {30'd0, done}, 0);
    end
    chk("cont_twohot", hot, 0);
    req = 2'b00;
    tick();

    // Reset during cycle 5 of a 16-word job
    rst = 1'b1; tick(); rst = 1'b0;
    cfg(0, 10'h100, 10'h10F, 1'b1);
    req[0] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_busy_pre", {31'd0, busy}, 1);
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0;
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_gnt", {30'd0, gnt}, 0);
    chk("mid_rd_en", {31'd0, rd_en}, 0);
    chk("mid_result", {24'd0, result}, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done != 2'b00) seen++;
      tick();
    end
    chk("mid_no_done", seen, 0);

    // Inputs changed and req dropped right after grant
    mem[10'h200] = 8'h50; mem[10'h201] = 8'h40; mem[10'h202] = 8'h60; mem[10'h203] = 8'h70;
    run_job("chg", 0, 10'h200, 10'h203, 1'b0, 4, 8'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
